slice_buffer_reader: RTL and testbench



---
 rtl/slice_buffer_reader_pkg.sv | 32 +++
 rtl/coeff_position_tracker.sv | 39 +++
 rtl/slice_buffer_reader.sv | 181 ++++++++++++++++++
 tb/tb_slice_buffer_reader.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_buffer_reader_pkg.sv
`default_nettype none
// slice_buffer_reader_pkg: tag codes, word field positions and FSM encodings shared with the slice decoder.
package slice_buffer_reader_pkg;

    localparam int TAG_W = 14;
    localparam int TAG_MSB = 31;
    localparam int TAG_LSB = 18;

    localparam logic [TAG_W-1:0] INFO_SLICE_QUANT  = 14'h0001;
    localparam logic [TAG_W-1:0] INFO_MB_QUANT     = 14'h0002;
    localparam logic [TAG_W-1:0] INFO_BLOCK_START  = 14'h0003;
    localparam logic [TAG_W-1:0] INFO_COEFF        = 14'h0004;
    localparam logic [TAG_W-1:0] INFO_END_OF_BLOCK = 14'h0005;

    localparam int RUN_MSB    = 17;
    localparam int RUN_LSB    = 12;
    localparam int LEVEL_MSB  = 11;
    localparam int LEVEL_LSB  = 0;
    localparam int BLKNUM_MSB = 2;
    localparam int BLKNUM_LSB = 0;
    localparam int INTRA_BIT  = 3;
    localparam int SCALE_MSB  = 4;

    typedef enum logic [1:0] {
        SBR_IDLE   = 2'd0,
        SBR_WAIT   = 2'd1,
        SBR_DECODE = 2'd2,
        SBR_OUTPUT = 2'd3
    } sbr_state_e;

endpackage
`default_nettype wire

// File: rtl/coeff_position_tracker.sv
`default_nettype none
// coeff_position_tracker: next zigzag index of the open block and the range check of next_index + run.
module coeff_position_tracker (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       advance_i,
    input  logic [5:0] run_i,
    output logic [5:0] index_o,
    output logic       in_range_o
);
    logic [6:0] next_index_q;
    logic [6:0] next_index_d;
    logic [6:0] w_pos;

    // Seven bits wide so that next_index can sit at 64 after a coefficient at 63.
    assign w_pos      = next_index_q + {1'b0, run_i};
    assign index_o    = w_pos[5:0];
    assign in_range_o = (w_pos <= 7'd63);

    always_comb begin
        next_index_d = next_index_q;
        if (clear_i) begin
            next_index_d = 7'd0;
        end else if (advance_i) begin
            next_index_d = w_pos + 7'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            next_index_q <= 7'd0;
        end else begin
            next_index_q <= next_index_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/slice_buffer_reader.sv
`default_nettype none
// slice_buffer_reader: pops tagged words from the slice buffer and turns quantiser,
// block and run/level words into an indexed coefficient stream with valid/ready.
module slice_buffer_reader
    import slice_buffer_reader_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Slice_Buffer_Value_I,
    input  logic        Slice_Buffer_Empty_I,
    output logic        Slice_Buffer_Read_En_O,
    input  logic        Flush_I,
    output logic [4:0]  Quantiser_Scale_O,
    output logic [2:0]  Block_Num_O,
    output logic        Block_Intra_O,
    output logic        Coeff_Valid_O,
    input  logic        Coeff_Ready_I,
    output logic [5:0]  Coeff_Index_O,
    output logic [11:0] Coeff_Level_O,
    output logic        Coeff_Last_O,
    output logic        Protocol_Error_O
);
    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

    sbr_state_e  state_q, state_d;
    logic [1:0]  lat_q, lat_d;
    logic [31:0] word_q, word_d;
    logic        in_block_q, in_block_d;
    logic [4:0]  scale_q, scale_d;
    logic [2:0]  bnum_q, bnum_d;
    logic        intra_q, intra_d;
    logic [5:0]  index_q, index_d;
    logic [11:0] level_q, level_d;
    logic        last_q, last_d;
    logic        perr_q, perr_d;

    logic [TAG_W-1:0] w_tag;
    logic [5:0]       w_index;
    logic             w_in_range;
    logic             w_decode;
    logic             w_coeff_ok;
    logic             w_eob_ok;

    assign w_tag      = word_q[TAG_MSB:TAG_LSB];
    assign w_decode   = (state_q == SBR_DECODE) && !Flush_I;
    assign w_coeff_ok = w_decode && (w_tag == INFO_COEFF) && in_block_q && w_in_range;
    assign w_eob_ok   = w_decode && (w_tag == INFO_END_OF_BLOCK) && in_block_q;

    coeff_position_tracker u_tracker (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (Flush_I || (w_decode && (w_tag == INFO_BLOCK_START))),
        .advance_i  (w_coeff_ok),
        .run_i      (word_q[RUN_MSB:RUN_LSB]),
        .index_o    (w_index),
        .in_range_o (w_in_range)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SBR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SBR_IDLE:   if (!Slice_Buffer_Empty_I) state_d = SBR_WAIT;
            SBR_WAIT:   if (lat_q == 2'd0) state_d = SBR_DECODE;
            SBR_DECODE: state_d = (w_coeff_ok || w_eob_ok) ? SBR_OUTPUT : SBR_IDLE;
            SBR_OUTPUT: if (Coeff_Ready_I) state_d = SBR_IDLE;
            default:    state_d = SBR_IDLE;
        endcase
        if (Flush_I) begin
            state_d = SBR_IDLE;
        end
    end

    // The pop strobe is combinational so the data returns exactly READ_LATENCY cycles later.
    always_comb begin
        Slice_Buffer_Read_En_O = (state_q == SBR_IDLE) && !Slice_Buffer_Empty_I && !Flush_I && !reset;
        Coeff_Valid_O          = (state_q == SBR_OUTPUT);
    end

    always_comb begin
        lat_d      = lat_q;
        word_d     = word_q;
        in_block_d = in_block_q;
        scale_d    = scale_q;
        bnum_d     = bnum_q;
        intra_d    = intra_q;
        index_d    = index_q;
        level_d    = level_q;
        last_d     = last_q;
        perr_d     = 1'b0;
        if (state_q == SBR_IDLE) begin
            lat_d = LAT_INIT;
        end else if (state_q == SBR_WAIT) begin
            if (lat_q == 2'd0) begin
                word_d = Slice_Buffer_Value_I;
            end else begin
                lat_d = lat_q - 2'd1;
            end
        end
        if (w_decode) begin
            case (w_tag)
                INFO_SLICE_QUANT, INFO_MB_QUANT: begin
                    scale_d = word_q[SCALE_MSB:0];
                end
                INFO_BLOCK_START: begin
                    bnum_d     = word_q[BLKNUM_MSB:BLKNUM_LSB];
                    intra_d    = word_q[INTRA_BIT];
                    in_block_d = 1'b1;
                    perr_d     = in_block_q;
                end
                INFO_COEFF: begin
                    if (in_block_q && w_in_range) begin
                        index_d = w_index;
                        level_d = word_q[LEVEL_MSB:LEVEL_LSB];
                        last_d  = 1'b0;
                    end else if (in_block_q) begin
                        perr_d     = 1'b1;
                        in_block_d = 1'b0;
                    end
                end
                INFO_END_OF_BLOCK: begin
                    if (in_block_q) begin
                        index_d    = 6'd0;
                        level_d    = 12'd0;
                        last_d     = 1'b1;
                        in_block_d = 1'b0;
                    end
                end
                default: perr_d = 1'b1;
            endcase
        end
        if (Flush_I) begin
            in_block_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lat_q      <= 2'd0;
            word_q     <= 32'd0;
            in_block_q <= 1'b0;
            scale_q    <= 5'd0;
            bnum_q     <= 3'd0;
            intra_q    <= 1'b0;
            index_q    <= 6'd0;
            level_q    <= 12'd0;
            last_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            lat_q      <= lat_d;
            word_q     <= word_d;
            in_block_q <= in_block_d;
            scale_q    <= scale_d;
            bnum_q     <= bnum_d;
            intra_q    <= intra_d;
            index_q    <= index_d;
            level_q    <= level_d;
            last_q     <= last_d;
            perr_q     <= perr_d;
        end
    end

    assign Quantiser_Scale_O = scale_q;
    assign Block_Num_O       = bnum_q;
    assign Block_Intra_O     = intra_q;
    assign Coeff_Index_O     = index_q;
    assign Coeff_Level_O     = level_q;
    assign Coeff_Last_O      = last_q;
    assign Protocol_Error_O  = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_slice_buffer_reader.sv
`default_nettype none
// tb_slice_buffer_reader: directed and random word streams against a stream-level reference model.
module tb_slice_buffer_reader;
    import slice_buffer_reader_pkg::*;

    localparam int READ_LATENCY = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] value;
    logic        empty = 1'b1;
    logic        rd_en;
    logic        flush = 1'b0;
    logic [4:0]  qs;
    logic [2:0]  bn;
    logic        bi;
    logic        cv;
    logic        cr = 1'b0;
    logic [5:0]  ci;
    logic [11:0] cl;
    logic        clast;
    logic        perr;

    always #5 clock = ~clock;

    slice_buffer_reader #(.READ_LATENCY(READ_LATENCY)) u_dut (
        .clock                  (clock),
        .reset                  (reset),
        .Slice_Buffer_Value_I   (value),
        .Slice_Buffer_Empty_I   (empty),
        .Slice_Buffer_Read_En_O (rd_en),
        .Flush_I                (flush),
        .Quantiser_Scale_O      (qs),
        .Block_Num_O            (bn),
        .Block_Intra_O          (bi),
        .Coeff_Valid_O          (cv),
        .Coeff_Ready_I          (cr),
        .Coeff_Index_O          (ci),
        .Coeff_Level_O          (cl),
        .Coeff_Last_O           (clast),
        .Protocol_Error_O       (perr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Behavioural slice buffer: a queue with a READ_LATENCY-deep return path.
    logic [31:0] fifo[$];
    logic [31:0] stim_q[$];
    logic [31:0] pipe0 = 32'd0;
    logic [31:0] pipe1 = 32'd0;
    logic        pop_req = 1'b0;

    assign value = (READ_LATENCY == 1) ? pipe0 : pipe1;

    always @(posedge clock) begin
        if (pop_req) begin
            chk("pop_nonempty", fifo.size() != 0, 1);
            if (fifo.size() != 0) pipe0 <= fifo.pop_front();
        end
        pipe1 <= pipe0;
        empty <= (fifo.size() == 0);
    end

    // Monitor: counts pops and error pulses, checks handshake rules, records transfers, drives ready.
    int          rdy_mode  = 0;
    int          stall_cnt = 0;
    int          rd_cnt    = 0;
    int          err_cnt   = 0;
    logic [18:0] act_q[$];
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_ctl = 1'b0, prev_err = 1'b0;
    logic [18:0] prev_f = 19'd0;

    always @(negedge clock) begin : p_mon
        logic [18:0] f;
        f = {clast, ci, cl};
        pop_req = rd_en;
        if (!reset) begin
            if (rd_en) rd_cnt++;
            if (perr) begin
                err_cnt++;
                chk("err_one_cycle", prev_err, 0);
            end
            if (prev_v && !prev_r && !prev_ctl) begin
                chk("valid_held", cv, 1);
                chk("fields_held", f, prev_f);
            end
            if (cv) chk("no_pop_while_valid", rd_en, 0);
        end
        if (rdy_mode != 3) stall_cnt = 0;
        case (rdy_mode)
            0: cr = 1'b1;
            1: cr = ($urandom_range(0, 3) != 0);
            2: cr = 1'b0;
            default: begin
                if (cv && stall_cnt < 4) begin
                    cr = 1'b0;
                    stall_cnt++;
                end else begin
                    cr = 1'b1;
                end
            end
        endcase
        if (cv && cr && !reset) act_q.push_back(f);
        prev_v   = cv;
        prev_r   = cr;
        prev_f   = f;
        prev_err = perr;
        prev_ctl = flush | reset;
    end

    // Reference model: stream-level semantics of each word.
    int          m_scale = 0, m_bnum = 0, m_intra = 0, m_in = 0, m_next = 0, m_err = 0;
    logic [18:0] exp_q[$];
    int          act_base = 0, rd_base = 0, err_base = 0;

    function automatic logic [31:0] mk(input logic [13:0] t, input logic [17:0] p);
        return {t, p};
    endfunction

    function automatic void model_reset();
        m_scale = 0; m_bnum = 0; m_intra = 0; m_in = 0; m_next = 0;
    endfunction

    function automatic void model_word(input logic [31:0] w);
        logic [13:0] t;
        int pos;
        t = w[31:18];
        if (t == INFO_SLICE_QUANT || t == INFO_MB_QUANT) begin
            m_scale = int'(w[4:0]);
        end else if (t == INFO_BLOCK_START) begin
            if (m_in != 0) m_err++;
            m_in = 1; m_next = 0;
            m_bnum = int'(w[2:0]);
            m_intra = int'(w[3]);
        end else if (t == INFO_COEFF) begin
            if (m_in != 0) begin
                pos = m_next + int'(w[17:12]);
                if (pos <= 63) begin
                    exp_q.push_back({1'b0, 6'(pos), w[11:0]});
                    m_next = pos + 1;
                end else begin
                    m_err++;
                    m_in = 0;
                end
            end
        end else if (t == INFO_END_OF_BLOCK) begin
            if (m_in != 0) begin
                exp_q.push_back({1'b1, 18'd0});
                m_in = 0;
            end
        end else begin
            m_err++;
        end
    endfunction

    task automatic begin_stream();
        act_base = act_q.size();
        rd_base  = rd_cnt;
        err_base = err_cnt;
        exp_q.delete();
        m_err = 0;
    endtask

    task automatic drain();
        int quiet = 0;
        int cyc = 0;
        while (quiet < 8 && cyc < 3000) begin
            @(negedge clock);
            cyc++;
            if (fifo.size() == 0 && !cv) quiet++;
            else quiet = 0;
        end
        chk("drain_done", quiet, 8);
    endtask

    task automatic check_results(input int n_words);
        int na;
        na = act_q.size() - act_base;
        chk("beat_count", na, exp_q.size());
        for (int i = 0; i < na && i < exp_q.size(); i++) chk("beat", act_q[act_base + i], exp_q[i]);
        chk("err_count", err_cnt - err_base, m_err);
        chk("pop_count", rd_cnt - rd_base, n_words);
        chk("qscale", qs, m_scale);
        chk("block_num", bn, m_bnum);
        chk("block_intra", bi, m_intra);
    endtask

    task automatic run_stream();
        @(posedge clock);
        #1;
        begin_stream();
        foreach (stim_q[i]) begin
            model_word(stim_q[i]);
            fifo.push_back(stim_q[i]);
        end
        drain();
        check_results(stim_q.size());
    endtask

    task automatic gen_random(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) begin
            int r;
            logic [17:0] p;
            r = $urandom_range(0, 99);
            p = 18'($urandom);
            if (r < 8) stim_q.push_back(mk(INFO_SLICE_QUANT, p));
            else if (r < 14) stim_q.push_back(mk(INFO_MB_QUANT, p));
            else if (r < 26) stim_q.push_back(mk(INFO_BLOCK_START, p));
            else if (r < 78) begin
                if ($urandom_range(0, 9) != 0) p[17:12] = 6'($urandom_range(0, 5));
                stim_q.push_back(mk(INFO_COEFF, p));
            end
            else if (r < 94) stim_q.push_back(mk(INFO_END_OF_BLOCK, p));
            else stim_q.push_back(mk(14'($urandom_range(16'h0100, 16'h3FFF)), p));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

    initial begin
        int c;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_state", {rd_en, qs, bn, bi, cv, ci, cl, clast, perr}, 0);
        reset = 1'b0;

        // Single quantiser word: one pop, scale visible within READ_LATENCY+2 cycles.
        rdy_mode = 0;
        @(posedge clock);
        #1;
        begin_stream();
        model_word(mk(INFO_SLICE_QUANT, 18'h0000C));
        fifo.push_back(mk(INFO_SLICE_QUANT, 18'h0000C));
        c = 0;
        while (!rd_en && c < 50) begin
            @(negedge clock);
            c++;
        end
        chk("quant_pop_seen", rd_en, 1);
        repeat (READ_LATENCY + 2) @(posedge clock);
        #1;
        chk("quant_latency", qs, 5'h0C);
        drain();
        check_results(1);

        // Basic block with ready always high, then the same with a stalled first beat.
        stim_q = '{mk(INFO_BLOCK_START, 18'h0000A), mk(INFO_COEFF, {6'd0, 12'h005}),
                   mk(INFO_COEFF, {6'd3, 12'hFFE}), mk(INFO_END_OF_BLOCK, 18'h0)};
        run_stream();
        rdy_mode = 3;
        run_stream();
        chk("stall_used", stall_cnt, 4);
        rdy_mode = 0;

        // Position overflow past 63, then the trailing EOB is dropped.
        stim_q = '{mk(INFO_BLOCK_START, 18'h00005), mk(INFO_COEFF, {6'd63, 12'h011}),
                   mk(INFO_COEFF, {6'd0, 12'h022}), mk(INFO_END_OF_BLOCK, 18'h0)};
        run_stream();

        // Unknown tag then a quantiser word.
        stim_q = '{mk(14'h3FFF, 18'h0), mk(INFO_SLICE_QUANT, 18'h00009)};
        run_stream();

        // Flush while a beat is waiting, then an orphan coefficient.
        rdy_mode = 2;
        @(posedge clock);
        #1;
        begin_stream();
        model_word(mk(INFO_BLOCK_START, 18'h00001));
        model_word(mk(INFO_COEFF, {6'd5, 12'h123}));
        exp_q.delete();
        fifo.push_back(mk(INFO_BLOCK_START, 18'h00001));
        fifo.push_back(mk(INFO_COEFF, {6'd5, 12'h123}));
        c = 0;
        while (!cv && c < 100) begin
            @(negedge clock);
            c++;
        end
        chk("flush_valid_before", cv, 1);
        @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        chk("flush_valid_after", cv, 0);
        m_in = 0; m_next = 0;
        rdy_mode = 0;
        model_word(mk(INFO_COEFF, {6'd0, 12'h007}));
        fifo.push_back(mk(INFO_COEFF, {6'd0, 12'h007}));
        drain();
        check_results(3);

        // Random streams with random backpressure.
        rdy_mode = 1;
        for (int k = 0; k < 6; k++) begin
            gen_random(40);
            run_stream();
        end

        // Reset asserted while a pop is in flight.
        rdy_mode = 0;
        @(posedge clock);
        #1;
        fifo.push_back(mk(INFO_SLICE_QUANT, 18'h00015));
        c = 0;
        while (!rd_en && c < 50) begin
            @(negedge clock);
            c++;
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("reset_mid_wait", {rd_en, qs, bn, bi, cv, ci, cl, clast, perr}, 0);
        fifo.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();

        rdy_mode = 1;
        gen_random(30);
        run_stream();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
